// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter
// Two requesters share one 4-bit ripple-adder slice through a round-robin
// arbiter. A WIDTH-bit sum is built one nibble per cycle, least significant
// nibble first, with the inter-nibble carry held in a register. The result,
// carry-out and requester ID are returned over a valid/ready response channel.
module adder_share_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             rsp_id
);

    localparam int NCHUNK = WIDTH / 4;
    // Counter is at least one bit wide so WIDTH=4 still elaborates cleanly.
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    // Operation context captured at accept
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             id_q;
    logic             last_id;

    // Nibble sequencing
    logic [CNT_W-1:0] k;
    logic             carry;
    logic [WIDTH-1:0] sum_q;
    logic             last_chunk;

    // Arbitration
    logic             grant0;
    logic             grant1;
    logic             accept;
    logic             accept_id;

    // Shared slice
    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [3:0]       slice_sum;
    logic             slice_cout;

    // Ripple chain of the single 4-bit slice: {carry-out, sum}.
    function automatic logic [4:0] slice_add(input logic [3:0] x,
                                             input logic [3:0] y,
                                             input logic       ci);
        logic [3:0] s;
        logic       c;
        c = ci;
        for (int i = 0; i < 4; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c, s};
    endfunction

    // Round-robin grant: a lone valid requester always wins; on a tie the
    // requester that was not served last wins.
    always_comb begin
        grant0    = req0_valid && (!req1_valid || last_id);
        grant1    = req1_valid && (!req0_valid || !last_id);
        accept    = (state == IDLE) && (grant0 || grant1);
        accept_id = grant1;
    end

    assign last_chunk = (k == CNT_W'(NCHUNK - 1));

    // Select the nibble of each latched operand addressed by the chunk counter.
    always_comb begin
        nib_a = 4'h0;
        nib_b = 4'h0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (k == CNT_W'(i)) begin
                nib_a = a_q[i*4 +: 4];
                nib_b = b_q[i*4 +: 4];
            end
        end
    end

    // The one adder slice in the design, fed by the carry register.
    always_comb begin
        {slice_cout, slice_sum} = slice_add(nib_a, nib_b, carry);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept)                 state_next = RUN;
            RUN:  if (last_chunk)             state_next = DONE;
            DONE: if (rsp_valid && rsp_ready) state_next = IDLE;
            default:                          state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        req0_ready = (state == IDLE) && grant0;
        req1_ready = (state == IDLE) && grant1;
        rsp_valid  = (state == DONE);
    end

    // Capture operands, ID and fairness pointer of the accepted requester;
    // inputs are ignored for the rest of the operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= 1'b0;
            last_id <= 1'b1;
        end else if (accept) begin
            a_q     <= accept_id ? req1_a : req0_a;
            b_q     <= accept_id ? req1_b : req0_b;
            id_q    <= accept_id;
            last_id <= accept_id;
        end
    end

    // Chunk counter restarts at accept and advances once per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k <= '0;
        end else if (accept) begin
            k <= '0;
        end else if (state == RUN) begin
            k <= k + 1'b1;
        end
    end

    // Carry register holds cin for chunk 0, then each slice carry-out; after
    // the last chunk it is the carry out of bit WIDTH-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry <= 1'b0;
        end else if (accept) begin
            carry <= accept_id ? req1_cin : req0_cin;
        end else if (state == RUN) begin
            carry <= slice_cout;
        end
    end

    // Write the slice result into the nibble addressed by the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else if (state == RUN) begin
            for (int i = 0; i < NCHUNK; i++) begin
                if (k == CNT_W'(i)) begin
                    sum_q[i*4 +: 4] <= slice_sum;
                end
            end
        end
    end

    // Response fields come straight from registers, so they hold steady
    // while the consumer stalls in DONE.
    assign rsp_sum  = sum_q;
    assign rsp_cout = carry;
    assign rsp_id   = id_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed testbench for adder_share_arbiter (WIDTH=16).
module tb_adder_share_arbiter;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_cin;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_cin;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_sum;
    logic             rsp_cout;
    logic             rsp_id;

    int compared   = 0;
    int mismatched = 0;

    adder_share_arbiter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_cin   (req0_cin),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_cin   (req1_cin),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout),
        .rsp_id     (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count edges until rsp_valid is seen, bounded at 30.
    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 30) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        compared++;
        if ({rsp_valid, rsp_cout, rsp_id, req0_ready, req1_ready} !== 5'b00000) begin
            mismatched++;
            $display("FAIL reset_ctrl: got %b want 00000",
                     {rsp_valid, rsp_cout, rsp_id, req0_ready, req1_ready});
        end
        compared++;
        if (rsp_sum !== 16'h0000) begin
            mismatched++;
            $display("FAIL reset_sum: got %h want 0000", rsp_sum);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int lat;
        req0_a = 16'h1234; req0_b = 16'h0FFF; req0_cin = 1'b0; req0_valid = 1'b1;
        #1;
        compared++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            mismatched++;
            $display("FAIL basic_ready_pre: got %b want 10", {req0_ready, req1_ready});
        end
        tick();
        compared++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            mismatched++;
            $display("FAIL basic_ready_post: got %b want 00", {req0_ready, req1_ready});
        end
        req0_valid = 1'b0;
        wait_rsp(lat);
        compared++;
        if (lat !== 4) begin
            mismatched++;
            $display("FAIL basic_latency: got %0d want 4", lat);
        end
        compared++;
        if ({rsp_cout, rsp_id, rsp_sum} !== {1'b0, 1'b0, 16'h2233}) begin
            mismatched++;
            $display("FAIL basic_result: got cout=%b id=%b sum=%h want cout=0 id=0 sum=2233",
                     rsp_cout, rsp_id, rsp_sum);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        compared++;
        if (rsp_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL basic_rsp_drop: got %b want 0", rsp_valid);
        end
    endtask

    task automatic test_carry_ripple();
        int lat;
        req1_a = 16'hFFFF; req1_b = 16'h0000; req1_cin = 1'b1; req1_valid = 1'b1;
        #1;
        compared++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            mismatched++;
            $display("FAIL carry_ready: got %b want 01", {req0_ready, req1_ready});
        end
        tick();
        req1_valid = 1'b0;
        wait_rsp(lat);
        compared++;
        if (lat !== 4) begin
            mismatched++;
            $display("FAIL carry_latency: got %0d want 4", lat);
        end
        compared++;
        if ({rsp_cout, rsp_id, rsp_sum} !== {1'b1, 1'b1, 16'h0000}) begin
            mismatched++;
            $display("FAIL carry_result: got cout=%b id=%b sum=%h want cout=1 id=1 sum=0000",
                     rsp_cout, rsp_id, rsp_sum);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_arbitration();
        int lat;
        logic exp_id;
        logic [15:0] exp_sum;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        req0_a = 16'h0001; req0_b = 16'h0001; req0_cin = 1'b0;
        req1_a = 16'h8000; req1_b = 16'h8000; req1_cin = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        rsp_ready  = 1'b1;
        for (int g = 0; g < 8; g++) begin
            exp_id  = (g % 2 == 1);
            exp_sum = exp_id ? 16'h0000 : 16'h0002;
            #1;
            compared++;
            if ({req0_ready, req1_ready} !== (exp_id ? 2'b01 : 2'b10)) begin
                mismatched++;
                $display("FAIL arb_grant[%0d]: got %b want %b", g,
                         {req0_ready, req1_ready}, (exp_id ? 2'b01 : 2'b10));
            end
            tick();
            wait_rsp(lat);
            compared++;
            if ({lat == 4, rsp_id, rsp_cout, rsp_sum} !== {1'b1, exp_id, exp_id, exp_sum}) begin
                mismatched++;
                $display("FAIL arb_rsp[%0d]: got lat=%0d id=%b cout=%b sum=%h want lat=4 id=%b cout=%b sum=%h",
                         g, lat, rsp_id, rsp_cout, rsp_sum, exp_id, exp_id, exp_sum);
            end
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        req1_a = 16'hF0F0; req1_b = 16'h1F10; req1_cin = 1'b0; req1_valid = 1'b1;
        rsp_ready = 1'b0;
        #1;
        tick();
        req0_a = 16'h0001; req0_b = 16'h0001; req0_cin = 1'b0; req0_valid = 1'b1;
        wait_rsp(lat);
        compared++;
        if ({lat == 4, rsp_cout, rsp_id, rsp_sum} !== {1'b1, 1'b1, 1'b1, 16'h1000}) begin
            mismatched++;
            $display("FAIL bp_result: got lat=%0d cout=%b id=%b sum=%h want lat=4 cout=1 id=1 sum=1000",
                     lat, rsp_cout, rsp_id, rsp_sum);
        end
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if ({rsp_valid, rsp_cout, rsp_id, rsp_sum, req0_ready, req1_ready}
                !== {1'b1, 1'b1, 1'b1, 16'h1000, 1'b0, 1'b0}) begin
                bad++;
            end
        end
        compared++;
        if (bad !== 0) begin
            mismatched++;
            $display("FAIL bp_hold: got %0d unstable cycles want 0", bad);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        compared++;
        if ({rsp_valid, req0_ready, req1_ready} !== 3'b010) begin
            mismatched++;
            $display("FAIL bp_release: got valid/r0/r1=%b want 010",
                     {rsp_valid, req0_ready, req1_ready});
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int bad;
        req0_a = 16'h1234; req0_b = 16'h1111; req0_cin = 1'b0; req0_valid = 1'b1;
        #1;
        tick();
        req0_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        compared++;
        if ({rsp_valid, rsp_cout, rsp_id, rsp_sum, req0_ready, req1_ready} !== 21'h0) begin
            mismatched++;
            $display("FAIL midrst_async: got valid=%b cout=%b id=%b sum=%h want all zero",
                     rsp_valid, rsp_cout, rsp_id, rsp_sum);
        end
        tick();
        tick();
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (rsp_valid !== 1'b0) bad++;
        end
        compared++;
        if (bad !== 0) begin
            mismatched++;
            $display("FAIL midrst_no_rsp: got %0d response cycles want 0", bad);
        end
        req0_a = 16'h00FF; req0_b = 16'h0001; req0_cin = 1'b0; req0_valid = 1'b1;
        #1;
        tick();
        req0_valid = 1'b0;
        wait_rsp(lat);
        compared++;
        if ({lat == 4, rsp_cout, rsp_id, rsp_sum} !== {1'b1, 1'b0, 1'b0, 16'h0100}) begin
            mismatched++;
            $display("FAIL midrst_next: got lat=%0d cout=%b id=%b sum=%h want lat=4 cout=0 id=0 sum=0100",
                     lat, rsp_cout, rsp_id, rsp_sum);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_operand_change();
        int lat;
        req0_a = 16'h1111; req0_b = 16'h1111; req0_cin = 1'b0; req0_valid = 1'b1;
        #1;
        tick();
        req0_a = 16'hFFFF;
        req0_valid = 1'b0;
        wait_rsp(lat);
        compared++;
        if ({lat == 4, rsp_cout, rsp_sum} !== {1'b1, 1'b0, 16'h2222}) begin
            mismatched++;
            $display("FAIL opchange: got lat=%0d cout=%b sum=%h want lat=4 cout=0 sum=2222",
                     lat, rsp_cout, rsp_sum);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
        rsp_ready  = 1'b0;

        test_reset();
        test_basic();
        test_carry_ripple();
        test_arbitration();
        test_backpressure();
        test_reset_mid_run();
        test_operand_change();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
